// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: the state encoding used by the control,
// display and digit-counter blocks.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    function automatic logic is_timing(input sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low pushbutton -> 2-FF synchronizer -> level debouncer ->
// one-cycle registered press pulse on the released-to-pressed transition.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized level agrees with the accepted level restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = deb_dly_q & ~deb_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= i_btn_n;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and lap/clear buttons drive the
// run/pause/lap FSM and the tick prescaler feeding the digit counters.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 10_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_ss_n,
    input  logic       i_btn_lap_n,
    output logic       o_cnt_en,
    output logic       o_cnt_clr,
    output logic       o_disp_hold,
    output logic [1:0] o_state
);

    import stopwatch_pkg::*;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    sw_state_e     state_q, state_d;
    logic          hold_q, hold_d;
    logic          en_q, en_d;
    logic          clr_q, clr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ss_ev, lap_ev;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_btn_ss_n),
        .o_press (ss_ev)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_btn_lap_n),
        .o_press (lap_ev)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clr_d   = 1'b0;
        en_d    = 1'b0;
        presc_d = presc_q;

        if (ss_ev) begin
            case (state_q)
                ST_IDLE:  begin state_d = ST_RUN; hold_d = 1'b0; end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: begin state_d = ST_RUN; hold_d = 1'b0; end
                ST_LAP:   state_d = ST_PAUSE;
                default:  ;
            endcase
        end else if (lap_ev) begin
            case (state_q)
                ST_IDLE:  clr_d = 1'b1;
                ST_RUN:   begin state_d = ST_LAP; hold_d = 1'b1; end
                ST_LAP:   begin state_d = ST_RUN; hold_d = 1'b0; end
                ST_PAUSE: begin
                    if (hold_q) begin
                        hold_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        clr_d   = 1'b1;
                    end
                end
                default:  ;
            endcase
        end

        // Only count across edges where timing continues, so pausing keeps the partial interval intact.
        if (is_timing(state_q) && is_timing(state_d)) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                en_d    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_d == ST_IDLE) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            presc_q <= presc_d;
        end
    end

    assign o_cnt_en    = en_q;
    assign o_cnt_clr   = clr_q;
    assign o_disp_hold = hold_q;
    assign o_state     = state_q;

endmodule
